// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, word width and instruction constants.
package cpu_pkg;

    localparam int XLEN = 32;

    // Canonical NOP (addi x0, x0, 0).
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_t;

    // Force a target address onto a 32-bit word boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register; loads RESET_VEC on reset, otherwise follows pc_next.
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_next,
    output logic [XLEN-1:0] pc_out
);

    // PC state; the parent supplies pc_out as pc_next when holding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_out <= RESET_VEC;
        else     pc_out <= pc_next;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, a single-entry
// output buffer towards decode, and trap/branch redirects that squash in-flight work.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] mtvec_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_instr_o
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] redirect_target;
    logic            redirect;
    logic            consume;
    logic            granted;
    logic            accept;

    // Trap wins over a branch redirect; both targets are word aligned.
    assign redirect        = trap_i | redirect_valid_i;
    assign redirect_target = align_word(trap_i ? mtvec_i : redirect_pc_i);

    // Decode takes the buffered instruction this cycle.
    assign consume = if_valid_o & ~stall_i;

    // Request only when the buffer will have room for the answer. This term
    // depends on stall_i in the same cycle, so the request is combinational
    // from the state register rather than a flop of its own.
    assign imem_req_o  = (state == ST_FETCH) & (~if_valid_o | ~stall_i);
    assign imem_addr_o = pc;
    assign granted     = imem_req_o & imem_gnt_i;

    // A response is kept only if no redirect squashes it in the same cycle.
    assign accept = (state == ST_WAIT) & imem_rvalid_i & ~redirect;

    // Next PC: redirect target, sequential advance on a kept response, or hold.
    always_comb begin
        pc_next = pc;
        if (redirect)    pc_next = redirect_target;
        else if (accept) pc_next = pc + 32'd4;
    end

    pc_reg #(
        .RESET_VEC(RESET_VEC)
    ) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .pc_next (pc_next),
        .pc_out  (pc)
    );

    // Fetch sequencing: track the single outstanding request and whether its
    // response must be thrown away after a redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  state <= ST_FETCH;
                ST_FETCH: begin
                    // A request granted in the redirect cycle is already stale.
                    if (granted) state <= redirect ? ST_DROP : ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rvalid_i) state <= ST_FETCH;
                    else if (redirect) state <= ST_DROP;
                end
                ST_DROP: begin
                    if (imem_rvalid_i) state <= ST_FETCH;
                end
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Output buffer: fill on a kept response, empty on consume or redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid_o <= 1'b0;
            if_pc_o    <= '0;
            if_instr_o <= '0;
        end else if (redirect) begin
            if_valid_o <= 1'b0;
        end else if (accept) begin
            if_valid_o <= 1'b1;
            if_pc_o    <= pc;
            if_instr_o <= imem_rdata_i;
        end else if (consume) begin
            if_valid_o <= 1'b0;
        end
    end

    // An ungranted request keeps its address until granted or redirected.
    a_req_hold: assert property (@(posedge clk) disable iff (rst)
        imem_req_o && !imem_gnt_i && !redirect |=> imem_req_o && $stable(imem_addr_o));

    // Requests are issued only into an empty buffer, so it stays empty while waiting.
    a_wait_empty: assert property (@(posedge clk) disable iff (rst)
        (state == ST_WAIT) |-> !if_valid_o);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: memory responder, directed scenarios, randomized traffic,
// and a monitor comparing the DUT against an architectural model of the fetch stream.
module tb_fetch_ctrl;
    import cpu_pkg::*;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, redirect_valid_i, trap_i;
    logic [31:0] redirect_pc_i, mtvec_i;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o, if_instr_o;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_VEC(RV)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .trap_i           (trap_i),
        .mtvec_i          (mtvec_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .if_valid_o       (if_valid_o),
        .if_pc_o          (if_pc_o),
        .if_instr_o       (if_instr_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents as a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // ---------------- memory responder ----------------
    bit          gnt_always = 1'b1;
    int          gnt_pct    = 60;
    int          lat_min    = 0;
    int          lat_max    = 0;
    bit          mem_pend   = 1'b0;
    logic [31:0] mem_addr;
    int          mem_cnt;

    initial begin
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            imem_rvalid_i = 1'b0;
            if (mem_pend) begin
                if (mem_cnt == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = mem_word(mem_addr);
                    mem_pend      = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end
            imem_gnt_i = !mem_pend && (gnt_always || ($urandom_range(99) < gnt_pct));
            #2;
            if (imem_req_o && imem_gnt_i) begin
                mem_pend = 1'b1;
                mem_addr = imem_addr_o;
                mem_cnt  = $urandom_range(lat_max, lat_min);
            end
        end
    end

    // ---------------- reference model + monitor ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_nf, m_addr, tgt;
    bit          m_idle, m_live, m_dead, m_vld;
    bit          redir, grant, consume, exp_req, nlive, ndead;

    initial begin
        m_nf = RV; m_addr = RV; m_idle = 1'b1;
        m_live = 1'b0; m_dead = 1'b0; m_vld = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                chk("rst_req",   {31'b0, imem_req_o}, 32'd0);
                chk("rst_valid", {31'b0, if_valid_o}, 32'd0);
                chk("rst_if_pc", if_pc_o, 32'd0);
                chk("rst_instr", if_instr_o, 32'd0);
                chk("rst_addr",  imem_addr_o, RV);
                m_nf = RV; m_idle = 1'b1; m_live = 1'b0; m_dead = 1'b0; m_vld = 1'b0;
                q.delete();
            end else begin
                redir   = trap_i || redirect_valid_i;
                tgt     = (trap_i ? mtvec_i : redirect_pc_i) & 32'hFFFF_FFFC;
                exp_req = !m_idle && !m_live && !m_dead && (!m_vld || !stall_i);
                chk("imem_req", {31'b0, imem_req_o}, {31'b0, exp_req});
                chk("if_valid", {31'b0, if_valid_o}, {31'b0, m_vld});
                if (m_vld && q.size() > 0) begin
                    chk("if_pc",    if_pc_o,    q[0].pc);
                    chk("if_instr", if_instr_o, q[0].instr);
                end
                if (imem_req_o) chk("imem_addr", imem_addr_o, m_nf);
                grant   = imem_req_o && imem_gnt_i;
                consume = m_vld && !stall_i;

                nlive = m_live;
                ndead = m_dead;
                if (imem_rvalid_i) begin
                    nlive = 1'b0;
                    ndead = 1'b0;
                end
                if (redir) begin
                    if (nlive) begin nlive = 1'b0; ndead = 1'b1; end
                    if (grant) ndead = 1'b1;
                    m_nf  = tgt;
                    m_vld = 1'b0;
                    q.delete();
                end else begin
                    if (consume) begin
                        m_vld = 1'b0;
                        if (q.size() > 0) void'(q.pop_front());
                    end
                    if (imem_rvalid_i && m_live) begin
                        q.push_back('{m_addr, mem_word(m_addr)});
                        m_vld = 1'b1;
                        m_nf  = m_addr + 32'd4;
                    end
                    if (grant) begin
                        nlive  = 1'b1;
                        m_addr = m_nf;
                    end
                end
                m_live = nlive;
                m_dead = ndead;
                m_idle = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_valid(input string name);
        int n = 0;
        do begin @(negedge clk); #1; n++; end while (!if_valid_o && n < 50);
        chk(name, {31'b0, if_valid_o}, 32'd1);
    endtask

    task automatic wait_grant(input string name);
        int n = 0;
        bit g = 1'b0;
        do begin @(negedge clk); #2; g = imem_req_o && imem_gnt_i; n++; end while (!g && n < 50);
        chk(name, {31'b0, g}, 32'd1);
    endtask

    initial begin
        int r;
        rst = 1'b1; stall_i = 1'b0; redirect_valid_i = 1'b0; trap_i = 1'b0;
        redirect_pc_i = '0; mtvec_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // sequential fetch from reset vector, grant always, 1-cycle response
        repeat (12) @(negedge clk);

        // stall with a full buffer: outputs hold, no new request
        stall_i = 1'b1;
        wait_valid("fill_before_stall");
        repeat (5) @(negedge clk);
        stall_i = 1'b0;
        repeat (4) @(negedge clk);

        // redirect while waiting on a slow response
        lat_min = 2; lat_max = 2;
        wait_grant("grant_before_redirect");
        @(negedge clk);
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h0000_0102;
        @(negedge clk);
        redirect_valid_i = 1'b0;
        repeat (10) @(negedge clk);

        // trap and redirect together: trap target wins
        lat_min = 0; lat_max = 0;
        @(negedge clk);
        trap_i = 1'b1; mtvec_i = 32'h0000_0200;
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h0000_0304;
        @(negedge clk);
        trap_i = 1'b0; redirect_valid_i = 1'b0;
        repeat (8) @(negedge clk);

        // address wrap at the top of memory
        redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid_i = 1'b0;
        repeat (10) @(negedge clk);

        // reset while a response is outstanding; late response must be ignored
        lat_min = 2; lat_max = 2;
        wait_grant("grant_before_reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // randomized traffic
        gnt_always = 1'b0; lat_min = 0; lat_max = 3;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            rst     = ($urandom_range(399) == 0);
            stall_i = ($urandom_range(99) < 30);
            r       = $urandom_range(99);
            trap_i           = (r < 3);
            redirect_valid_i = (r < 1) || (r >= 3 && r < 10);
            redirect_pc_i    = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
            mtvec_i          = $urandom;
        end
        @(negedge clk);
        rst = 1'b0; stall_i = 1'b0; trap_i = 1'b0; redirect_valid_i = 1'b0;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
